button_control_bank: RTL

- Parametrised, multi-channel successor to the single-key edge/toggle controller used by the stopwatch front panel.
- Each channel performs these steps on a raw board key:
  - synchronises it;
  - applies a polarity fix;
  - debounces it;
  - produces press and release pulses, a toggle-mode bit with synchronous clear, and an optional long-press pulse.
- Sits between the board KEY pins and the stopwatch/clock control FSMs.

---
 rtl/button_control_bank.sv | 125 ++++++++++++
 1 files changed

// File: rtl/button_control_bank.sv
// Multi-channel key front end: two-flop synchroniser, polarity fix, debounce, press/release
// pulses and toggle mode. Define BUTTON_LONG_PRESS_EN to build the long-press hold counters.
module button_control_bank #(
  parameter int unsigned CHANNELS        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned HOLD_CYCLES     = 50000000
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [CHANNELS-1:0] i_key_in,
  input  logic [CHANNELS-1:0] i_mode_clear,
  output logic [CHANNELS-1:0] o_pressed,
  output logic [CHANNELS-1:0] o_press_pulse,
  output logic [CHANNELS-1:0] o_release_pulse,
  output logic [CHANNELS-1:0] o_mode,
  output logic [CHANNELS-1:0] o_hold_pulse
);

  localparam logic             IDLE_LEVEL = ACTIVE_LOW;
  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Elaboration-time parameter sanity checks.
  if (CHANNELS < 1) begin : g_bad_channels
    $error("button_control_bank: CHANNELS must be at least 1");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("button_control_bank: DEBOUNCE_CYCLES must be at least 1");
  end
  if ((CNT_W < 32) && ((DEBOUNCE_CYCLES - 1) >= (32'd1 << CNT_W))) begin : g_bad_cnt_w
    $error("button_control_bank: CNT_W too narrow for DEBOUNCE_CYCLES-1");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("button_control_bank: HOLD_CYCLES must be at least 1");
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    logic             r_sync0;
    logic             r_sync1;
    logic             r_pressed;
    logic             r_press_pulse;
    logic             r_release_pulse;
    logic             r_mode;
    logic [CNT_W-1:0] r_cnt;
    logic             w_level;
    logic             w_differs;
    logic             w_accept;
    logic             w_pressed_next;
    logic [CNT_W-1:0] w_cnt_next;

    assign w_level = ACTIVE_LOW ? ~r_sync1 : r_sync1;

    // Any return to the stable level restarts the count, so short glitches never land.
    always_comb begin
      w_differs      = (w_level != r_pressed);
      w_accept       = w_differs && (r_cnt == DB_LAST);
      w_pressed_next = w_accept ? w_level : r_pressed;
      w_cnt_next     = (!w_differs || w_accept) ? '0 : r_cnt + CNT_W'(1);
    end

    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        r_sync0         <= IDLE_LEVEL;
        r_sync1         <= IDLE_LEVEL;
        r_cnt           <= '0;
        r_pressed       <= 1'b0;
        r_press_pulse   <= 1'b0;
        r_release_pulse <= 1'b0;
        r_mode          <= 1'b0;
      end else begin
        r_sync0         <= i_key_in[g];
        r_sync1         <= r_sync0;
        r_cnt           <= w_cnt_next;
        r_pressed       <= w_pressed_next;
        r_press_pulse   <= w_accept && w_level;
        r_release_pulse <= w_accept && !w_level;
        if (i_mode_clear[g]) begin
          r_mode <= 1'b0;
        end else if (w_accept && w_level) begin
          r_mode <= ~r_mode;
        end
      end
    end

`ifdef BUTTON_LONG_PRESS_EN
    localparam logic [31:0] HOLD_LAST = 32'(HOLD_CYCLES);

    logic [31:0] r_hold_cnt;
    logic [31:0] w_hold_next;
    logic        r_hold_pulse;

    // Counts on the next pressed value so the press_pulse cycle reads as count 1.
    always_comb begin
      if (!w_pressed_next) begin
        w_hold_next = '0;
      end else if (r_hold_cnt == HOLD_LAST) begin
        w_hold_next = r_hold_cnt;
      end else begin
        w_hold_next = r_hold_cnt + 32'd1;
      end
    end

    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        r_hold_cnt   <= '0;
        r_hold_pulse <= 1'b0;
      end else begin
        r_hold_cnt   <= w_hold_next;
        r_hold_pulse <= (w_hold_next == HOLD_LAST) && (r_hold_cnt != HOLD_LAST);
      end
    end

    assign o_hold_pulse[g] = r_hold_pulse;
`else
    assign o_hold_pulse[g] = 1'b0;
`endif

    assign o_pressed[g]       = r_pressed;
    assign o_press_pulse[g]   = r_press_pulse;
    assign o_release_pulse[g] = r_release_pulse;
    assign o_mode[g]          = r_mode;
  end

endmodule
